encrypt_round_iter: RTL and testbench
=====================================

// Module: encrypt_round_iter
// PURPOSE
//  Iterative AES-128 encryption datapath: forward counterpart of the decrypt round chain.
//  Accepts one 128-bit plaintext block, runs initial AddRoundKey + ROUNDS rounds, one round per clock.
//  Holds the ciphertext until the consumer takes it.
//  Round keys are fetched by index from the external key store, which returns them combinationally in the same cycle.
// PARAMETERS
//  ROUNDS   10   number of cipher rounds after initial AddRoundKey (AES-128 = 10; last round omits MixColumns)
//  KIW      4    width of key_idx; must hold 0..ROUNDS
// PORTS
//  clk        in   1    single clock, all state on posedge
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    plaintext offered
//  in_ready   out  1    block can accept plaintext
//  state_in   in   128  plaintext, FIPS-197 byte order (bits[127:120] = byte 0, column-major)
//  key_idx    out  KIW  round-key index requested this cycle
//  round_key  in   128  round key[key_idx], valid same cycle
//  out_valid  out  1    ciphertext available
//  out_ready  in   1    consumer takes ciphertext
//  state_out  out  128  ciphertext, same byte order
// BEHAVIOUR
//  - FSM states: IDLE, ROUND, DONE.
//  - Registers: 128-bit state, round counter rnd (KIW bits).
//  - Reset: FSM=IDLE, rnd=0, state=0, out_valid=0, state_out=0.
//    in_ready=1 from reset release; key_idx=0.
//  - Outputs:
//    - in_ready=1 only in IDLE.
//    - out_valid=1 only in DONE; state_out = state reg in DONE, 0 otherwise.
//  - key_idx: 0 in IDLE; rnd in ROUND; 0 in DONE.
//  - IDLE, in_valid&in_ready: state<=state_in^round_key(idx0); rnd<=1; ->ROUND.
//    - in_valid low: hold IDLE.
//  - ROUND, rnd<ROUNDS: state<=MixColumns(ShiftRows(SubBytes(state)))^round_key; rnd<=rnd+1.
//  - ROUND, rnd==ROUNDS: state<=ShiftRows(SubBytes(state))^round_key (no MixColumns); rnd<=0; ->DONE.
//  - Round transform: pure combinational within one cycle; GF(2^8) xtime uses reduction polynomial 0x1B.
//  - DONE: out_valid held with stable state_out until out_ready=1.
//    - On that edge: ->IDLE, state_out returns to 0.
//    - out_ready high outside DONE: ignored.
//  - Latency: out_valid rises ROUNDS edges after the accepting edge (10 for AES-128).
//    Minimum initiation interval ROUNDS+2 cycles (12).
//  - in_valid during ROUND/DONE: ignored (in_ready=0); producer must hold.
//  - state_in/round_key are sampled only on the edge where they are used; no internal key storage.
//  - Async reset mid-operation: immediate return to reset values; partial block discarded, no output.
// CONFIGURATION
//  AES_ENC_ABORT_EN defined:
//    - Adds input abort (1 bit), placed after rst_n.
//    - abort=1 on any edge: FSM<=IDLE, rnd<=0, state<=0.
//    - out_valid drops next cycle.
//    - Priority over in_valid handshake and out_ready in the same cycle.
//  Not defined: no abort port. A block, once accepted, always completes to DONE.
// TESTING
//  1 FIPS-197 App.B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c.
//    Expect state_out 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 edges after accept.
//  2 FIPS-197 App.C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f.
//    Expect 69c4e0d86a7b0430d8cdb78070b4c55a.
//    Check key_idx sequence 0,1..10,0.
//  3 Backpressure: hold out_ready=0 for 7 cycles in DONE.
//    Expect out_valid=1 and state_out stable, in_ready=0; release -> IDLE, in_ready=1 next cycle.
//  4 Back-to-back: in_valid held high, out_ready=1.
//    Expect second accept exactly 12 cycles after first; both ciphertexts correct.
//  5 rst_n pulled low at round 5, then released.
//    Expect out_valid=0, state_out=0, in_ready=1, key_idx=0 during and after; next block encrypts correctly.
//  6 (AES_ENC_ABORT_EN) abort=1 at round 3 together with in_valid.
//    Expect IDLE next cycle, no out_valid, no accept that cycle; subsequent App.B vector correct.

Source files
------------

// File: rtl/encrypt_round_iter.sv
// Iterative AES-128 encryption: initial AddRoundKey on accept, then one full round per clock.
// Optional synchronous abort input is enabled by defining AES_ENC_ABORT_EN.
module encrypt_round_iter #(
    parameter int ROUNDS = 10,
    parameter int KIW    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef AES_ENC_ABORT_EN
    input  logic           abort,
`endif
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   state_in,
    output logic [KIW-1:0] key_idx,
    input  logic [127:0]   round_key,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   state_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // Entry 0 sits in the most significant byte of the table.
        return SBOX[{8'd255 - b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [1:0]     fsm_q, fsm_d;
    logic [KIW-1:0] rnd_q, rnd_d;
    logic [127:0]   state_q, state_d;

    logic [7:0]   sr_b [16];
    logic [7:0]   mc_b [16];
    logic [127:0] sr_w;
    logic [127:0] mc_w;

    genvar gi;

    // SubBytes fused with ShiftRows: byte (row r, col c) takes source column (c+r) mod 4.
    for (gi = 0; gi < 16; gi++) begin : g_sub
        localparam int SRC = 4 * (((gi / 4) + (gi % 4)) % 4) + (gi % 4);
        assign sr_b[gi] = sbox(state_q[127-8*SRC -: 8]);
    end

    for (gi = 0; gi < 4; gi++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr_b[4*gi];
        assign a1 = sr_b[4*gi+1];
        assign a2 = sr_b[4*gi+2];
        assign a3 = sr_b[4*gi+3];
        assign mc_b[4*gi]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mc_b[4*gi+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mc_b[4*gi+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mc_b[4*gi+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    for (gi = 0; gi < 16; gi++) begin : g_pack
        assign sr_w[127-8*gi -: 8] = sr_b[gi];
        assign mc_w[127-8*gi -: 8] = mc_b[gi];
    end

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = state_in ^ round_key;
                    rnd_d   = KIW'(1);
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                if (rnd_q == KIW'(ROUNDS)) begin
                    state_d = sr_w ^ round_key;
                    rnd_d   = '0;
                    fsm_d   = S_DONE;
                end else begin
                    state_d = mc_w ^ round_key;
                    rnd_d   = rnd_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d   = S_IDLE;
                rnd_d   = '0;
                state_d = '0;
            end
        endcase
`ifdef AES_ENC_ABORT_EN
        // Abort wins over both handshakes on the same edge.
        if (abort) begin
            fsm_d   = S_IDLE;
            rnd_d   = '0;
            state_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            rnd_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end

    assign in_ready  = (fsm_q == S_IDLE);
    assign out_valid = (fsm_q == S_DONE);
    assign state_out = out_valid ? state_q : 128'd0;
    assign key_idx   = (fsm_q == S_ROUND) ? rnd_q : '0;

endmodule

// File: tb/tb_encrypt_round_iter.sv
// Directed bench for encrypt_round_iter: FIPS-197 vectors, backpressure, back-to-back, mid-run reset.
// The abort sequence is compiled in only when AES_ENC_ABORT_EN is defined.
module tb_encrypt_round_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [3:0]   key_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
`ifdef AES_ENC_ABORT_EN
    logic         abort;
`endif

    encrypt_round_iter #(.ROUNDS(10), .KIW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef AES_ENC_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .key_idx   (key_idx),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // External key store: round keys from a software key schedule, returned combinationally.
    logic [127:0] rk [0:10];
    always_comb begin
        round_key = '0;
        if (key_idx <= 4'd10) round_key = rk[key_idx];
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           hold;
    } vec_t;
    vec_t vecs [3];

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX[{8'd255 - b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Accept one block, follow key_idx through the rounds, hold DONE for 'hold' cycles, then drain.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] ct, input int hold);
        int lat;
        check("idle_in_ready", in_ready, 1);
        check("idle_key_idx", key_idx, 0);
        state_in  = pt;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            check($sformatf("key_idx_r%0d", lat + 1), key_idx, lat + 1);
            cyc();
            lat++;
        end
        check("latency", lat, 10);
        check("ciphertext", state_out, ct);
        check("done_key_idx", key_idx, 0);
        for (int h = 0; h < hold; h++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_state_out", state_out, ct);
            check("bp_in_ready", in_ready, 0);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("drain_in_ready", in_ready, 1);
        check("drain_out_valid", out_valid, 0);
        check("drain_state_out", state_out, 0);
    endtask

    initial begin
        int acc_cyc [2];
        int n_acc;
        int n_out;
        logic seen;

        vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h3243f6a8885a308d313198a2e0370734,
                    ct: 128'h3925841d02dc09fbdc118597196a0b32, hold: 0};
        vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f, pt: 128'h00112233445566778899aabbccddeeff,
                    ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, hold: 7};
        vecs[2] = '{key: 128'h0, pt: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, hold: 0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
`ifdef AES_ENC_ABORT_EN
        abort     = 1'b0;
`endif
        load_key(vecs[0].key);
        cyc();
        cyc();
        check("rst_out_valid", out_valid, 0);
        check("rst_state_out", state_out, 0);
        check("rst_key_idx", key_idx, 0);
        rst_n = 1'b1;
        cyc();
        check("rel_in_ready", in_ready, 1);

        for (int v = 0; v < 3; v++) begin
            load_key(vecs[v].key);
            run_block(vecs[v].pt, vecs[v].ct, vecs[v].hold);
        end

        // Back-to-back with the key store switched while the first block is in DONE.
        load_key(vecs[0].key);
        state_in  = vecs[0].pt;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n_acc = 0;
        n_out = 0;
        for (int c = 0; c < 40 && n_out < 2; c++) begin
            if (in_valid && in_ready && n_acc < 2) begin
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            if (out_valid) begin
                check($sformatf("b2b_ct%0d", n_out), state_out, (n_out == 0) ? vecs[0].ct : vecs[1].ct);
                n_out++;
                if (n_out == 1) begin
                    load_key(vecs[1].key);
                    state_in = vecs[1].pt;
                end
            end
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_outputs", n_out, 2);
        check("b2b_accepts", n_acc, 2);
        check("b2b_interval", (n_acc == 2) ? (acc_cyc[1] - acc_cyc[0]) : -1, 12);
        cyc();

        // Asynchronous reset in the middle of round 5.
        load_key(vecs[0].key);
        state_in = vecs[0].pt;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 20 && key_idx != 4'd5; k++) cyc();
        check("reach_round5", key_idx, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_state_out", state_out, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_key_idx", key_idx, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_key_idx", key_idx, 0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid || state_out != 0) seen = 1'b1;
            cyc();
        end
        check("post_rst_no_output", seen, 0);
        load_key(vecs[1].key);
        run_block(vecs[1].pt, vecs[1].ct, 0);

`ifdef AES_ENC_ABORT_EN
        // Abort at round 3 with in_valid high: back to IDLE, nothing accepted on that edge.
        load_key(vecs[1].key);
        state_in = vecs[1].pt;
        in_valid = 1'b1;
        cyc();
        for (int k = 0; k < 20 && key_idx != 4'd3; k++) cyc();
        check("reach_round3", key_idx, 3);
        abort = 1'b1;
        cyc();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_key_idx", key_idx, 0);
        check("abort_out_valid", out_valid, 0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) seen = 1'b1;
            cyc();
        end
        check("abort_no_output", seen, 0);
        load_key(vecs[0].key);
        run_block(vecs[0].pt, vecs[0].ct, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
